// File: rtl/regfile_pkg.sv
// Shared register-block constants and the write-scheduler state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    // Write-port scheduler modes: normal arbitration, or hardware clear sweep.
    typedef enum logic [0:0] {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller gates gnt when it cannot accept.
module rr_arbiter #(
    parameter  int N     = 2,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;
    int   cand;

    // Scan requesters starting at ptr; the first one found gets the one-hot grant.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr) + off) % N;
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Round-robin scheduler for the register block's single write port, plus clear sweep.
// Latency: a transfer in cycle T appears on rf_we/rf_waddr/rf_wdata in cycle T+1.
// Backpressure: grant withheld while clearing or when clear_start is high; requesters hold until granted.
module regfile_write_sched
    import regfile_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int REG_COUNT = regfile_pkg::REG_COUNT,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter int ZERO_LOCK = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          grant,
    input  logic                     clear_start,
    output logic                     clear_busy,
    output logic                     rf_we,
    output logic [ADDR_W-1:0]        rf_waddr,
    output logic [DATA_W-1:0]        rf_wdata
);

    localparam int PTR_W = $clog2(NREQ);
    // One spare bit so the terminal count never aliases back to zero.
    localparam int CNT_W = $clog2(REG_COUNT) + 1;

    sched_state_t       state;
    logic [PTR_W-1:0]   rrPtr;
    logic [CNT_W-1:0]   sweepCnt;
    logic               lastSweep;

    logic [NREQ-1:0]    arbGnt;
    logic [PTR_W-1:0]   arbIdx;
    logic               arbEnable;
    logic               xferVld;
    logic               xferSuppress;
    logic [ADDR_W-1:0]  xferAddr;
    logic [DATA_W-1:0]  xferData;

    rr_arbiter #(
        .N (NREQ)
    ) uArb (
        .req     (req),
        .ptr     (rrPtr),
        .gnt     (arbGnt),
        .gnt_idx (arbIdx)
    );

    // A clear request in the same cycle beats any writeback.
    assign arbEnable    = (state == ARB) && !clear_start;
    assign grant        = arbEnable ? arbGnt : '0;
    assign xferVld      = |(req & grant);
    assign xferAddr     = req_addr[int'(arbIdx) * ADDR_W +: ADDR_W];
    assign xferData     = req_data[int'(arbIdx) * DATA_W +: DATA_W];
    // Register 0 is hardwired zero: accept the handshake but drop the write.
    assign xferSuppress = (ZERO_LOCK != 0) && (xferAddr == '0);

    assign lastSweep    = (sweepCnt == CNT_W'(REG_COUNT - 1));
    assign clear_busy   = (state == CLEAR);

    // Mode FSM and sweep counter; clear_start is ignored once a sweep is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB;
            sweepCnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (clear_start) begin
                        state    <= CLEAR;
                        sweepCnt <= '0;
                    end
                end
                CLEAR: begin
                    if (lastSweep) begin
                        state    <= ARB;
                        sweepCnt <= '0;
                    end else begin
                        sweepCnt <= sweepCnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ARB;
                    sweepCnt <= '0;
                end
            endcase
        end
    end

    // Round-robin pointer moves just past the winner; it is untouched by the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr <= '0;
        end else if (xferVld) begin
            rrPtr <= (arbIdx == PTR_W'(NREQ - 1)) ? '0 : arbIdx + 1'b1;
        end
    end

    // Registered write-port drive: sweep writes zeros, otherwise the granted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (state == CLEAR) begin
            rf_we    <= 1'b1;
            rf_waddr <= ADDR_W'(sweepCnt);
            rf_wdata <= '0;
        end else if (xferVld) begin
            rf_we    <= !xferSuppress;
            rf_waddr <= xferAddr;
            rf_wdata <= xferData;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_sched.sv
// Self-checking bench for regfile_write_sched: directed scenarios then random traffic.
// Latency: a reference model predicts grant each cycle and the write-port drive one cycle later.
// Backpressure: emulated requesters hold req/addr/data until granted, occasionally dropping.
module tb_regfile_write_sched;
    import regfile_pkg::*;

    localparam int NREQ = 2;
    localparam int AW   = REG_ADDR_W;
    localparam int DW   = REG_DATA_W;
    localparam int RC   = REG_COUNT;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      grant;
    logic                 clear_start;
    logic                 clear_busy;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [DW-1:0]        rf_wdata;

    always #5 clk = ~clk;

    regfile_write_sched #(
        .NREQ      (NREQ),
        .REG_COUNT (RC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .ZERO_LOCK (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .grant       (grant),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: whose turn it is, how many sweep writes remain, next expected write.
    int            mPtr      = 0;
    int            busyLeft  = 0;
    int            sweepIdx  = 0;
    logic          expWe     = 1'b0;
    logic [AW-1:0] expAddr   = '0;
    logic [DW-1:0] expData   = '0;
    int            lastG     = -1;
    logic [NREQ-1:0] lastGrant;
    int            weCount   = 0;

    // Behavioural register block fed by the write port.
    logic [DW-1:0] tbMem [RC];

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        testsRun++;
        if (obs !== expv) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic setReq(input int i, input logic on, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]              = on;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // One clock cycle: check grant, let the edge happen, update model, check write port.
    task automatic tick();
        int            g;
        logic [NREQ-1:0] expGnt;
        logic          capWe;
        logic [AW-1:0] capA;
        logic [DW-1:0] capD;
        logic [AW-1:0] gA;
        logic [DW-1:0] gD;
        #1;
        g = -1;
        if (busyLeft == 0 && !clear_start) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req[(mPtr + k) % NREQ]) g = (mPtr + k) % NREQ;
            end
        end
        expGnt = '0;
        if (g >= 0) expGnt[g] = 1'b1;
        if (!reset) checkVal("grant", 64'(grant), 64'(expGnt));
        lastGrant = grant;
        capWe = rf_we;
        capA  = rf_waddr;
        capD  = rf_wdata;
        gA    = '0;
        gD    = '0;
        if (g >= 0) begin
            gA = req_addr[g*AW +: AW];
            gD = req_data[g*DW +: DW];
        end
        @(posedge clk);
        if (capWe) tbMem[capA] = capD;
        lastG = -1;
        if (reset) begin
            mPtr = 0; busyLeft = 0; sweepIdx = 0;
            expWe = 1'b0; expAddr = '0; expData = '0;
        end else if (busyLeft > 0) begin
            expWe = 1'b1; expAddr = AW'(sweepIdx); expData = '0;
            sweepIdx++;
            busyLeft--;
        end else if (clear_start) begin
            busyLeft = RC; sweepIdx = 0; expWe = 1'b0;
        end else if (g >= 0) begin
            expWe   = (gA != '0);
            expAddr = gA;
            expData = gD;
            mPtr    = (g + 1) % NREQ;
            lastG   = g;
        end else begin
            expWe = 1'b0;
        end
        #1;
        checkVal("rf_we", 64'(rf_we), 64'(expWe));
        if (expWe) begin
            checkVal("rf_waddr", 64'(rf_waddr), 64'(expAddr));
            checkVal("rf_wdata", 64'(rf_wdata), 64'(expData));
        end
        checkVal("clear_busy", 64'(clear_busy), 64'(busyLeft > 0));
        if (rf_we) weCount++;
        @(negedge clk);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < RC; i++) tbMem[i] = 32'hEEEE_0000 | i;
        reset = 1'b1; req = '0; req_addr = '0; req_data = '0; clear_start = 1'b0;
        @(negedge clk);
        tick();
        tick();
        checkVal("reset_waddr", 64'(rf_waddr), 64'h0);
        checkVal("reset_wdata", 64'(rf_wdata), 64'h0);
        reset = 1'b0;

        // Both requesters held: strict alternation starting at requester 0.
        setReq(0, 1'b1, 5'd3, 32'hA);
        setReq(1, 1'b1, 5'd7, 32'hB);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("t1_grant", 64'(lastGrant), (i % 2 == 0) ? 64'h1 : 64'h2);
        end
        req = '0;
        tick();

        // Lone requester 1 wins back-to-back; afterwards turn returns to requester 0.
        setReq(1, 1'b1, 5'd12, 32'h1200);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal("t2_grant", 64'(lastGrant), 64'h2);
        end
        setReq(0, 1'b1, 5'd4, 32'h0400);
        tick();
        checkVal("t2_ptr_wrap", 64'(lastGrant), 64'h1);
        req = '0;
        tick();

        // Clear sweep collides with a request; a second clear_start mid-sweep is ignored.
        setReq(0, 1'b1, 5'd9, 32'h1234);
        clear_start = 1'b1;
        weCount = 0;
        tick();
        checkVal("t4_clear_wins", 64'(lastGrant), 64'h0);
        clear_start = 1'b0;
        for (int k = 1; k <= RC; k++) begin
            clear_start = (k == 6);
            tick();
        end
        clear_start = 1'b0;
        checkVal("t6_sweep_writes", 64'(weCount), 64'(RC));
        tick();
        checkVal("t4_resume_grant", 64'(lastGrant), 64'h1);
        bad = 0;
        for (int i = 0; i < RC; i++) if (tbMem[i] != '0) bad++;
        checkVal("t4_mem_zeroed", 64'(bad), 64'h0);

        // Register 0 is write-protected: handshake completes, no write issued.
        setReq(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        checkVal("t3_grant", 64'(lastGrant), 64'h1);
        checkVal("t3_we_low", 64'(rf_we), 64'h0);
        req = '0;
        tick();
        tick();
        checkVal("t3_r0", 64'(tbMem[0]), 64'h0);
        checkVal("t3_r9", 64'(tbMem[9]), 64'h1234);

        // Fill r10..r31, then reset in sweep cycle 10: the sweep stops dead.
        for (int i = 10; i < RC; i++) begin
            setReq(1, 1'b1, AW'(i), 32'h5500_0000 | i);
            tick();
        end
        req = '0;
        tick();
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        reset = 1'b1;
        tick();
        checkVal("t5_we_after_reset", 64'(rf_we), 64'h0);
        checkVal("t5_busy_after_reset", 64'(clear_busy), 64'h0);
        reset = 1'b0;
        setReq(0, 1'b1, 5'd2, 32'h22);
        tick();
        checkVal("t5_arb_after_reset", 64'(lastGrant), 64'h1);
        req = '0;
        tick();
        tick();
        bad = 0;
        for (int i = 0; i < RC; i++) begin
            if (i == 2) begin
                if (tbMem[i] != 32'h22) bad++;
            end else if (i < 10) begin
                if (tbMem[i] != '0) bad++;
            end else if (tbMem[i] != (32'h5500_0000 | i)) begin
                bad++;
            end
        end
        checkVal("t5_mem_contents", 64'(bad), 64'h0);

        // Random traffic with occasional clears, drops and resets.
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && ($urandom % 3 == 0))
                    setReq(i, 1'b1, AW'($urandom_range(0, RC - 1)), DW'($urandom));
                else if (req[i] && ($urandom % 16 == 0))
                    req[i] = 1'b0;
            end
            clear_start = ($urandom % 80 == 0);
            reset       = ($urandom % 250 == 0);
            tick();
            if (lastG >= 0) req[lastG] = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
